vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
Shares one single-port pixel memory between two requesters: display scan-out, which prefetches into a pixel FIFO, and a host write port. Sits between the VGA timing generator (hcount/vcount/pixel_enable) and the RGB output register. Display reads have priority, and a starvation guard bounds host wait time. Each frame's fetch is re-aligned at the start of vertical blanking.

Parameters:
HSYNC_BITS, 11, hcount width
VSYNC_BITS, 11, vcount width
HD, 1280, active pixels per line
VD, 1024, active lines per frame
ADDR_W, 21, memory address width; 2**ADDR_W >= HD*VD
DATA_W, 12, pixel width (4:4:4 RGB)
FIFO_DEPTH, 16, pixel FIFO entries, power of two, >= 4
MAX_WAIT, 8, host starvation limit in cycles, >= 1

Ports:
clk  in  1  system/pixel clock
arstn  in  1  reset, active-low
hcount  in  HSYNC_BITS  horizontal position from timing generator
vcount  in  VSYNC_BITS  vertical position from timing generator
pixel_enable  in  1  active-area strobe; pops one pixel per cycle
host_valid  in  1  host write request
host_addr  in  ADDR_W  host write address
host_wdata  in  DATA_W  host write data
host_ready  out  1  host write accepted this cycle (combinational)
mem_req  out  1  memory access strobe
mem_we  out  1  1 = write (host), 0 = read (display)
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after a read mem_req
pix_data  out  DATA_W  registered pixel to RGB stage
underflow  out  1  sticky: a pop occurred while the FIFO was empty

Behaviour:
- Single clock: clk. Reset: arstn, synchronous, active-low. Every listed reset value applies on the first clk edge with arstn=0.
- Reset values: pix_data=0, underflow=0, FIFO empty, in-flight=0, fetch address=0, wait counter=0, state=S_RUN. mem_req=0 and host_ready=0 while arstn=0.
- The memory accepts one access per cycle and has no back-pressure.
- FSM states:
  - S_RUN: normal arbitration.
  - S_DONE: the fetch address has passed HD*VD-1. No display reads are issued; the host may be granted every cycle.
  - S_FLUSH: lasts 1 cycle. FIFO count and pointers are cleared, any in-flight read return is discarded, the fetch address is set to 0, and no mem_req is issued.
- FSM transitions:
  - Any state -> S_FLUSH when hcount==0 && vcount==VD (start of vertical blanking).
  - S_FLUSH -> S_RUN on the next cycle.
  - S_RUN -> S_DONE in the cycle after the read of address HD*VD-1 is issued.
- Display read eligibility: state==S_RUN && (count + inflight) < FIFO_DEPTH. A display grant drives mem_req=1, mem_we=0, mem_addr=fetch address, and the fetch address increments by 1.
- Host grant: taken when host_valid=1 and either no display read is eligible, or the wait counter equals MAX_WAIT. The forced grant overrides an eligible display read for that one cycle. A host grant drives mem_req=1, mem_we=1, mem_addr=host_addr, mem_wdata=host_wdata, host_ready=1.
- Host handshake: the host holds valid, addr and data stable until host_ready. No host grants are made in S_FLUSH.
- Wait counter:
  - Increments while host_valid=1 and the host is not granted; saturates at MAX_WAIT.
  - Clears on a host grant or when host_valid=0.
  - Guarantees host_ready within MAX_WAIT+1 cycles of valid, excluding S_FLUSH cycles.
- Read return: push mem_rdata into the FIFO in the cycle after a display read, unless S_FLUSH occurred in between. inflight is 0 or 1.
- Pop: pixel_enable=1 pops the FIFO head, and pix_data takes the head on the next edge (1-cycle latency).
  - Pop on empty: pix_data <= 0 and underflow <= 1; underflow stays set until reset.
  - pixel_enable=0: pix_data <= 0.
- Simultaneous push and pop: count is unchanged. Push and pop of the same entry when count==0 is not allowed; an empty pop takes priority as underflow, and the pushed data is still stored.
- FIFO can never overflow, by the eligibility rule.
- Arithmetic: count is $clog2(FIFO_DEPTH)+1 bits wide. The fetch address compare against HD*VD-1 is done at ADDR_W width; HD*VD-1 is computed as a constant.

Decomposition:
- Package vga_pkg:
  - pixel_t (logic [DATA_W-1:0])
  - arb_state_e {S_RUN, S_DONE, S_FLUSH}
  - default timing constants HD/VD
  - helper constant FRAME_PIXELS = HD*VD
- One sub-module, vga_pixel_fifo: synchronous FIFO with push, pop, flush and count outputs, on the same clk/arstn.
- Arbitration, FSM and wait counter stay in vga_fb_arbiter.

Test Plan:
- Reset, then idle with pixel_enable=0, starting at vcount=VD, hcount=0 → one S_FLUSH cycle, then reads of addresses 0..15 on consecutive cycles; mem_req drops with count=16; underflow=0.
- Prefilled memory (addr n holds n[11:0]), pixel_enable asserted for 32 cycles → pix_data = 0,1,...,31 one cycle after each pop; no gaps; no underflow.
- host_valid held continuously during a full-rate display stream → host_ready within 9 cycles (MAX_WAIT=8); that mem_req has mem_we=1 with the correct addr/data; the following display address is unskipped.
- FIFO empty, pixel_enable=1 for 1 cycle → pix_data=0, underflow=1 and still 1 after 100 further cycles.
- Read issued in the cycle before vcount=VD/hcount=0 → return data is discarded; count=0 after S_FLUSH; the next read address is 0.
- Drive arstn=0 for 1 cycle mid-frame with FIFO at 10 entries and host_valid=1 → all outputs reach their reset values on that edge; host_ready=0 during reset.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and default timing constants for the framebuffer arbiter.
package vga_pkg;

  localparam int unsigned DefHd        = 1280;
  localparam int unsigned DefVd        = 1024;
  localparam int unsigned DefDataW     = 12;
  localparam int unsigned FRAME_PIXELS = DefHd * DefVd;

  typedef logic [DefDataW-1:0] pixel_t;

  typedef enum logic [1:0] {
    S_RUN,
    S_DONE,
    S_FLUSH
  } arb_state_e;

endpackage

// File: rtl/vga_pixel_fifo.sv
// Synchronous pixel FIFO with single-cycle flush; pops on empty are ignored.
module vga_pixel_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 12
) (
  input  logic                       clk,
  input  logic                       arstn,
  input  logic                       push_i,
  input  logic [DATA_W-1:0]          wdata_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              do_pop;

  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push_i) wptr_d = wptr_q + 1'b1;
      if (do_pop) rptr_d = rptr_q + 1'b1;
      case ({push_i, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Arbitrates one single-port pixel memory between display prefetch and host writes.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned HSYNC_BITS = 11,
  parameter int unsigned VSYNC_BITS = 11,
  parameter int unsigned HD         = DefHd,
  parameter int unsigned VD         = DefVd,
  parameter int unsigned ADDR_W     = 21,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MAX_WAIT   = 8
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic [HSYNC_BITS-1:0] hcount,
  input  logic [VSYNC_BITS-1:0] vcount,
  input  logic                  pixel_enable,
  input  logic                  host_valid,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [DATA_W-1:0]     host_wdata,
  output logic                  host_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [DATA_W-1:0]     pix_data,
  output logic                  underflow
);

  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(HD * VD - 1);
  localparam logic [CntW:0]     DepthOcc = (CntW + 1)'(FIFO_DEPTH);
  localparam logic [WaitW-1:0]  MaxWait  = WaitW'(MAX_WAIT);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic              inflight_q;
  logic [DATA_W-1:0] pix_data_q, pix_data_d;
  logic              underflow_q, underflow_d;

  logic [DATA_W-1:0] fifo_rdata;
  logic [CntW-1:0]   fifo_count;
  logic              fifo_empty;
  logic [CntW:0]     occupancy;
  logic              frame_start, flushing, fifo_push;
  logic              disp_elig, disp_grant, host_grant;

  assign frame_start = (hcount == '0) && (vcount == VSYNC_BITS'(VD));
  assign flushing    = (state_q == S_FLUSH);
  // A return arriving in the flush cycle belongs to the previous frame.
  assign fifo_push   = inflight_q && !flushing;

  assign occupancy  = {1'b0, fifo_count} + {{CntW{1'b0}}, inflight_q};
  assign disp_elig  = arstn && (state_q == S_RUN) && (occupancy < DepthOcc);
  assign host_grant = arstn && host_valid && !flushing && (!disp_elig || wait_q == MaxWait);
  assign disp_grant = disp_elig && !host_grant;

  assign host_ready = host_grant;
  assign pix_data   = pix_data_q;
  assign underflow  = underflow_q;

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = fetch_addr_q;
    mem_wdata = '0;
    if (host_grant) begin
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (disp_grant) begin
      mem_req = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    unique case (state_q)
      S_RUN: begin
        if (disp_grant) begin
          fetch_addr_d = fetch_addr_q + 1'b1;
          if (fetch_addr_q == LastAddr) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_DONE;
      S_FLUSH: begin
        state_d      = S_RUN;
        fetch_addr_d = '0;
      end
      default: state_d = S_RUN;
    endcase
    if (frame_start) state_d = S_FLUSH;
  end

  always_comb begin
    wait_d = wait_q;
    if (!host_valid || host_grant) begin
      wait_d = '0;
    end else if (wait_q != MaxWait) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_comb begin
    pix_data_d  = '0;
    underflow_d = underflow_q;
    if (pixel_enable) begin
      if (fifo_empty) underflow_d = 1'b1;
      else            pix_data_d  = fifo_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_q      <= S_RUN;
      fetch_addr_q <= '0;
      wait_q       <= '0;
      inflight_q   <= 1'b0;
      pix_data_q   <= '0;
      underflow_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      wait_q       <= wait_d;
      inflight_q   <= disp_grant;
      pix_data_q   <= pix_data_d;
      underflow_q  <= underflow_d;
    end
  end

  vga_pixel_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .arstn   (arstn),
    .push_i  (fifo_push),
    .wdata_i (mem_rdata),
    .pop_i   (pixel_enable),
    .flush_i (flushing),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter with a small frame and a behavioural memory.
module tb_vga_fb_arbiter;

  localparam int unsigned Hd    = 16;
  localparam int unsigned Vd    = 8;
  localparam int unsigned Frame = Hd * Vd;

  logic        clk;
  logic        arstn;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        pixel_enable;
  logic        host_valid;
  logic [20:0] host_addr;
  logic [11:0] host_wdata;
  logic        host_ready;
  logic        mem_req;
  logic        mem_we;
  logic [20:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic [11:0] pix_data;
  logic        underflow;

  vga_fb_arbiter #(
    .HSYNC_BITS (11),
    .VSYNC_BITS (11),
    .HD         (Hd),
    .VD         (Vd),
    .ADDR_W     (21),
    .DATA_W     (12),
    .FIFO_DEPTH (16),
    .MAX_WAIT   (8)
  ) dut (
    .clk          (clk),
    .arstn        (arstn),
    .hcount       (hcount),
    .vcount       (vcount),
    .pixel_enable (pixel_enable),
    .host_valid   (host_valid),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_ready   (host_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .pix_data     (pix_data),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: address n holds n, one-cycle read latency.
  logic [11:0] mem [256];
  logic        init_mem;
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= 12'(i);
    end else if (mem_req) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  int          exp_rd_addr = 0;
  int          next_pix = 0;
  int          lat;
  bit          mon_en = 1'b0;
  bit          pe_prev = 1'b0;
  logic [11:0] exp_pix_q [$];
  logic [32:0] host_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic drive_pe(input bit v);
    pixel_enable = v;
    if (v) begin
      exp_pix_q.push_back(12'(next_pix));
      next_pix++;
    end
  endtask

  task automatic sample();
    logic [32:0] h;
    @(negedge clk);
    if (mon_en) begin
      if (pe_prev) begin
        if (exp_pix_q.size() == 0) chk("pix_sb_empty", 1, 0);
        else                       chk("pix", 32'(pix_data), 32'(exp_pix_q.pop_front()));
      end else begin
        chk("pix_idle", 32'(pix_data), 0);
      end
      if (mem_req && !mem_we) begin
        chk("rd_in_frame", 32'(exp_rd_addr < Frame), 1);
        chk("rd_addr", 32'(mem_addr), 32'(exp_rd_addr));
        exp_rd_addr++;
      end
      if (host_ready) begin
        chk("wr_req", 32'({mem_req, mem_we}), 32'b11);
        if (host_q.size() == 0) begin
          chk("wr_sb_empty", 1, 0);
        end else begin
          h = host_q.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(h[32:12]));
          chk("wr_data", 32'(mem_wdata), 32'(h[11:0]));
        end
      end
    end
  endtask

  task automatic advance();
    pe_prev = pixel_enable;
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic [20:0] a, input logic [11:0] d, input bit stream,
                            output int l);
    bit done;
    done = 1'b0;
    l    = 0;
    host_valid = 1'b1;
    host_addr  = a;
    host_wdata = d;
    host_q.push_back({a, d});
    for (int i = 0; i < 20 && !done; i++) begin
      drive_pe(stream);
      sample();
      l++;
      if (host_ready) done = 1'b1;
      advance();
    end
    host_valid = 1'b0;
    chk("host_done", 32'(done), 1);
    if (!done) host_q.delete();
  endtask

  task automatic frame_flush();
    hcount = '0;
    vcount = 11'(Vd);
    drive_pe(1'b0);
    sample();
    advance();
    exp_rd_addr = 0;
    hcount = 11'd1;
    drive_pe(1'b0);
    sample();
    chk("flush_no_req", 32'(mem_req), 0);
    advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    init_mem     = 1'b1;
    arstn        = 1'b0;
    hcount       = 11'd5;
    vcount       = 11'd0;
    pixel_enable = 1'b0;
    host_valid   = 1'b1;
    host_addr    = 21'd5;
    host_wdata   = 12'h777;
    @(posedge clk); #1;
    init_mem = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_pix", 32'(pix_data), 0);
    chk("rst_uf", 32'(underflow), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_hready", 32'(host_ready), 0);
    @(posedge clk); #1;
    host_valid = 1'b0;
    arstn      = 1'b1;
    mon_en     = 1'b1;

    // Frame start: one flush cycle, then 16 back-to-back reads fill the FIFO.
    frame_flush();
    for (int i = 0; i < 16; i++) begin
      drive_pe(1'b0);
      sample();
      chk("fill_req", 32'(mem_req), 1);
      advance();
    end
    for (int i = 0; i < 2; i++) begin
      drive_pe(1'b0);
      sample();
      chk("full_idle", 32'(mem_req), 0);
      advance();
    end
    chk("fill_uf", 32'(underflow), 0);

    // Host write while the display is idle and the FIFO is full: immediate grant.
    host_write(21'd230, 12'h3C3, 1'b0, lat);
    chk("host_lat_idle", 32'(lat), 1);

    for (int i = 0; i < 32; i++) begin
      drive_pe(1'b1);
      sample();
      advance();
    end
    drive_pe(1'b0);
    sample();
    advance();
    chk("stream_uf", 32'(underflow), 0);

    // Full-rate stream: host is forced in after MAX_WAIT cycles.
    for (int i = 0; i < 4; i++) begin
      drive_pe(1'b1);
      sample();
      advance();
    end
    host_write(21'd200, 12'hABC, 1'b1, lat);
    chk("host_lat_stream", 32'(lat), 9);
    for (int i = 0; i < 3; i++) begin
      drive_pe(1'b1);
      sample();
      advance();
    end
    drive_pe(1'b1);
    sample();
    chk("pre_flush_rd", 32'(mem_req && !mem_we), 1);
    advance();

    // Flush discards in-flight data; the first pop afterwards sees an empty FIFO.
    frame_flush();
    pixel_enable = 1'b1;
    exp_pix_q.push_back(12'h000);
    sample();
    advance();
    drive_pe(1'b0);
    sample();
    chk("uf_set", 32'(underflow), 1);
    advance();
    for (int i = 0; i < 100; i++) begin
      drive_pe(1'b0);
      sample();
      advance();
    end
    chk("uf_sticky", 32'(underflow), 1);

    // Stream the whole frame, then no read past the last pixel.
    next_pix = 0;
    for (int i = 0; i < int'(Frame); i++) begin
      drive_pe(1'b1);
      sample();
      advance();
    end
    for (int i = 0; i < 5; i++) begin
      drive_pe(1'b0);
      sample();
      chk("done_no_rd", 32'(mem_req), 0);
      advance();
    end
    chk("done_rd_count", 32'(exp_rd_addr), 32'(Frame));
    host_write(21'd210, 12'h5A5, 1'b0, lat);
    chk("host_lat_done", 32'(lat), 1);

    // Mid-frame reset with a partly filled FIFO and a pending host request.
    frame_flush();
    for (int i = 0; i < 11; i++) begin
      drive_pe(1'b0);
      sample();
      advance();
    end
    arstn      = 1'b0;
    host_valid = 1'b1;
    host_addr  = 21'd220;
    host_wdata = 12'h123;
    drive_pe(1'b0);
    sample();
    chk("mid_rst_hready", 32'(host_ready), 0);
    chk("mid_rst_req", 32'(mem_req), 0);
    advance();
    arstn       = 1'b1;
    exp_rd_addr = 0;
    host_write(21'd220, 12'h123, 1'b0, lat);
    chk("host_lat_rst", 32'(lat), 9);
    chk("mid_rst_uf", 32'(underflow), 0);
    for (int i = 0; i < 12; i++) begin
      drive_pe(1'b0);
      sample();
      advance();
    end
    chk("post_rst_reads", 32'(exp_rd_addr), 16);
    next_pix = 0;
    for (int i = 0; i < 4; i++) begin
      drive_pe(1'b1);
      sample();
      advance();
    end
    drive_pe(1'b0);
    sample();
    advance();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
